register_file: RTL and testbench
================================

# register_file

Architectural register file with rename tags for the out-of-order core. It holds the 32 committed integer register values. For each register it also keeps a busy bit and the RoB index of the youngest in-flight writer. The dispatcher reads operand status from it and records new destination tags in it. It is the receiving end of the RoB commit interface (register write-back plus flush).

## Interface
- RoB_WIDTH, 3, width of a RoB index/tag (RoB holds 2^RoB_WIDTH entries)
- clk_in  input  1  clock; all state updates on posedge
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global enable; low freezes all state
- commit_en  input  1  RoB commits a register write this cycle
- commit_reg  input  5  destination register of the commit
- commit_index  input  RoB_WIDTH  RoB index of the committing entry
- commit_data  input  32  committed value
- flush_signal  input  1  misprediction flush from RoB
- rename_en  input  1  dispatcher issues an instruction with a destination
- rename_reg  input  5  destination register being renamed
- rename_index  input  RoB_WIDTH  RoB index allocated to that instruction
- rs1_reg, rs2_reg  input  5 each  operand registers to look up
- rs1_busy, rs2_busy  output  1 each  operand still owned by an in-flight writer
- rs1_tag, rs2_tag  output  RoB_WIDTH each  RoB index of that writer; 0 when not busy
- rs1_value, rs2_value  output  32 each  register value; meaningful when not busy

## Operation
- State per register r (1..31): value[r] (32 bits), busy[r], tag[r]. Register x0 is hard-wired: value 0, never busy, tag 0. Writes and renames to x0 are ignored.
- **Commit** (commit_en && commit_reg != 0):
  - value[commit_reg] <= commit_data.
  - busy is cleared only when busy[commit_reg] is set and tag[commit_reg] == commit_index.
  - When the tag does not match, a younger writer owns the register. The value is still written, but busy and tag are unchanged.
- **Rename** (rename_en && rename_reg != 0): busy[rename_reg] <= 1, tag[rename_reg] <= rename_index.
- **Rename and commit on the same register in the same cycle:** the rename wins. busy stays 1 and tag becomes rename_index, while the value write still happens.
- **Flush** (flush_signal): all busy bits <= 0 and all tags <= 0. Values are kept. A commit in the same cycle still writes its value. rename_en is ignored during flush.
- **Lookup** is combinational, for each rsN:
  - rsN == 0: busy 0, tag 0, value 0.
  - Commit bypass condition: rdy_in && commit_en && commit_reg == rsN && busy[rsN] && tag[rsN] == commit_index. When it holds, report busy 0 and value commit_data.
  - Otherwise report busy[rsN], tag[rsN], and value = (rdy_in && commit_en && commit_reg == rsN) ? commit_data : value[rsN].
  - Lookup never reflects a same-cycle rename. Operands see the state from before their own instruction's destination is renamed, which is what makes add x1,x1,x2 correct.
- **rdy_in low:** no state changes. Lookups still reflect stored state, with no bypass.
- **Reset:** all values 0, busy 0, tags 0. All outputs follow, e.g. rs1_busy=0, rs1_tag=0, rs1_value=0.
- **Priority within a cycle:** rst_in, then !rdy_in, then flush, then normal update (rename overrides a commit's busy clear).

## Timing
- Commit value, busy clear, rename and flush all become visible in stored state at the posedge that samples them, and on lookups from the next cycle.
- A matching commit is visible on lookups in the same cycle through the bypass, with zero added latency.
- There is no handshake and no stall. One commit and one rename are accepted every cycle rdy_in is high.
- Tags wrap with RoB indices. Only equality is compared, with no age ordering, so wrap-around needs no special handling.

## Test plan
- **Reset, then commit:** pulse rst_in, then query x5 → busy 0, tag 0, value 0. Commit x5=0xDEADBEEF with tag 2 → the next cycle's query returns value 0xDEADBEEF, busy 0.
- **Matching tag:** rename x3 to tag 4, then query → busy 1, tag 4. Commit x3=7 with index 4 → same-cycle query gives busy 0, value 7; next cycle also busy 0, value 7.
- **Stale tag:** rename x3 to tag 1, then rename x3 to tag 5. Commit x3=9 with index 1 → busy stays 1, tag 5, stored value 9.
- **Same-cycle collision:** with x7 busy at tag 2, in one cycle commit x7=11 with index 2 and rename x7 to tag 6 → next cycle busy 1, tag 6, value 11.
- **Flush:** rename x1, x2 and x31, then assert flush together with rename x4 → next cycle all are busy 0 with tag 0, x4 is not busy, and values are unchanged.
- **x0 and rdy_in:** commit x0=5 and rename x0 → x0 reads 0 and not busy. With rdy_in low, commit x8=3 → next cycle x8 is unchanged.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and rename tag.
// Receives RoB commits and flushes; serves two combinational operand lookups.
module register_file #(
   parameter int RoB_WIDTH = 3
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 commit_en,
   input  logic [4:0]           commit_reg,
   input  logic [RoB_WIDTH-1:0] commit_index,
   input  logic [31:0]          commit_data,
   input  logic                 flush_signal,
   input  logic                 rename_en,
   input  logic [4:0]           rename_reg,
   input  logic [RoB_WIDTH-1:0] rename_index,
   input  logic [4:0]           rs1_reg,
   input  logic [4:0]           rs2_reg,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   output logic [RoB_WIDTH-1:0] rs1_tag,
   output logic [RoB_WIDTH-1:0] rs2_tag,
   output logic [31:0]          rs1_value,
   output logic [31:0]          rs2_value
);

   logic [31:0]          value_vec [32];
   logic                 busy_vec  [32];
   logic [RoB_WIDTH-1:0] tag_vec   [32];

   genvar gi;

   generate
      for (gi = 0; gi < 32; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign value_vec[gi] = '0;
            assign busy_vec[gi]  = 1'b0;
            assign tag_vec[gi]   = '0;
         end else begin : g_live
            logic [31:0]          value_reg;
            logic                 busy_reg;
            logic [RoB_WIDTH-1:0] tag_reg;
            logic                 commit_hit;
            logic                 rename_hit;

            assign commit_hit = commit_en && (commit_reg == 5'(gi));
            assign rename_hit = rename_en && (rename_reg == 5'(gi));

            // A rename in the same cycle overrides the commit's busy clear.
            always_ff @(posedge clk_in) begin
               if (rst_in) begin
                  value_reg <= '0;
                  busy_reg  <= 1'b0;
                  tag_reg   <= '0;
               end else if (rdy_in) begin
                  if (commit_hit)
                     value_reg <= commit_data;
                  if (flush_signal) begin
                     busy_reg <= 1'b0;
                     tag_reg  <= '0;
                  end else if (rename_hit) begin
                     busy_reg <= 1'b1;
                     tag_reg  <= rename_index;
                  end else if (commit_hit && busy_reg && (tag_reg == commit_index)) begin
                     busy_reg <= 1'b0;
                  end
               end
            end

            assign value_vec[gi] = value_reg;
            assign busy_vec[gi]  = busy_reg;
            assign tag_vec[gi]   = tag_reg;
         end
      end
   endgenerate

   logic [4:0]           rs_sel    [2];
   logic                 lk_busy   [2];
   logic [RoB_WIDTH-1:0] lk_tag    [2];
   logic [31:0]          lk_value  [2];

   assign rs_sel[0] = rs1_reg;
   assign rs_sel[1] = rs2_reg;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic                 busy_next;
         logic [RoB_WIDTH-1:0] tag_next;
         logic [31:0]          value_next;
         logic                 commit_hit;

         // Same-cycle commit is bypassed; a same-cycle rename is deliberately not.
         always_comb begin
            busy_next  = 1'b0;
            tag_next   = '0;
            value_next = '0;
            commit_hit = rdy_in && commit_en && (commit_reg == rs_sel[gi]);
            if (rs_sel[gi] != 5'd0) begin
               if (commit_hit && busy_vec[rs_sel[gi]] && (tag_vec[rs_sel[gi]] == commit_index)) begin
                  value_next = commit_data;
               end else begin
                  busy_next  = busy_vec[rs_sel[gi]];
                  tag_next   = busy_vec[rs_sel[gi]] ? tag_vec[rs_sel[gi]] : '0;
                  value_next = commit_hit ? commit_data : value_vec[rs_sel[gi]];
               end
            end
         end

         assign lk_busy[gi]  = busy_next;
         assign lk_tag[gi]   = tag_next;
         assign lk_value[gi] = value_next;
      end
   endgenerate

   assign rs1_busy  = lk_busy[0];
   assign rs2_busy  = lk_busy[1];
   assign rs1_tag   = lk_tag[0];
   assign rs2_tag   = lk_tag[1];
   assign rs1_value = lk_value[0];
   assign rs2_value = lk_value[1];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed scenarios plus randomized traffic
// checked against a behavioural model of the stored state and lookup rules.
module tb_register_file;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        commit_en;
   logic [4:0]  commit_reg;
   logic [2:0]  commit_index;
   logic [31:0] commit_data;
   logic        flush_signal;
   logic        rename_en;
   logic [4:0]  rename_reg;
   logic [2:0]  rename_index;
   logic [4:0]  rs1_reg, rs2_reg;
   logic        rs1_busy, rs2_busy;
   logic [2:0]  rs1_tag, rs2_tag;
   logic [31:0] rs1_value, rs2_value;

   register_file #(.RoB_WIDTH(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .commit_en(commit_en), .commit_reg(commit_reg), .commit_index(commit_index),
      .commit_data(commit_data), .flush_signal(flush_signal),
      .rename_en(rename_en), .rename_reg(rename_reg), .rename_index(rename_index),
      .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
      .rs1_value(rs1_value), .rs2_value(rs2_value)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      string       name;
      bit          port;
      logic        busy;
      logic [2:0]  tag;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [2:0]  m_tag  [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t mlook(input string n, input bit p, input logic [4:0] rs);
      exp_t e;
      logic hit;
      e.name = n; e.port = p; e.busy = 1'b0; e.tag = '0; e.value = '0;
      hit = rdy_in && commit_en && (commit_reg == rs);
      if (rs != 5'd0) begin
         if (hit && m_busy[rs] && (m_tag[rs] == commit_index)) begin
            e.value = commit_data;
         end else begin
            e.busy  = m_busy[rs];
            e.tag   = m_busy[rs] ? m_tag[rs] : 3'd0;
            e.value = hit ? commit_data : m_val[rs];
         end
      end
      return e;
   endfunction

   task automatic model_update();
      if (rst_in) begin
         for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
         end
      end else if (rdy_in) begin
         if (commit_en && commit_reg != 5'd0)
            m_val[commit_reg] = commit_data;
         if (flush_signal) begin
            for (int r = 0; r < 32; r++) begin
               m_busy[r] = 1'b0; m_tag[r] = '0;
            end
         end else begin
            if (commit_en && commit_reg != 5'd0 && m_busy[commit_reg] && m_tag[commit_reg] == commit_index)
               m_busy[commit_reg] = 1'b0;
            if (rename_en && rename_reg != 5'd0) begin
               m_busy[rename_reg] = 1'b1;
               m_tag[rename_reg]  = rename_index;
            end
         end
      end
   endtask

   task automatic idle();
      rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0;
      commit_en = 1'b0; commit_reg = '0; commit_index = '0; commit_data = '0;
      rename_en = 1'b0; rename_reg = '0; rename_index = '0;
      rs1_reg = '0; rs2_reg = '0;
   endtask

   task automatic expect_lit(input string n, input bit p, input logic b, input logic [2:0] t,
                             input logic [31:0] v);
      exp_t e;
      e.name = n; e.port = p; e.busy = b; e.tag = t; e.value = v;
      sb.push_back(e);
   endtask

   // Push model expectations, sample just before the edge, then advance one cycle.
   task automatic step(input bit chk);
      exp_t e;
      if (chk) begin
         sb.push_back(mlook("m_rs1", 1'b0, rs1_reg));
         sb.push_back(mlook("m_rs2", 1'b1, rs2_reg));
      end
      #4;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.name, ".busy"},  32'(e.port ? rs2_busy  : rs1_busy),  32'(e.busy));
         check({e.name, ".tag"},   32'(e.port ? rs2_tag   : rs1_tag),   32'(e.tag));
         check({e.name, ".value"}, e.port ? rs2_value : rs1_value, e.value);
      end
      @(posedge clk_in);
      model_update();
      @(negedge clk_in);
      idle();
   endtask

   function automatic logic [4:0] pick();
      int r;
      r = $urandom_range(0, 9);
      return (r < 8) ? 5'(r) : 5'd31;
   endfunction

   logic [4:0]  fl_regs [4];
   logic [31:0] fl_vals [4];

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
      idle();
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b1;
      step(1'b0);

      // reset, then commit
      rs1_reg = 5'd5; expect_lit("reset_x5", 0, 1'b0, 3'd0, 32'd0); step(1'b1);
      commit_en = 1'b1; commit_reg = 5'd5; commit_index = 3'd2; commit_data = 32'hDEADBEEF;
      rs1_reg = 5'd5; step(1'b1);
      rs1_reg = 5'd5; expect_lit("commit_x5", 0, 1'b0, 3'd0, 32'hDEADBEEF); step(1'b1);

      // matching tag
      rename_en = 1'b1; rename_reg = 5'd3; rename_index = 3'd4; step(1'b1);
      rs1_reg = 5'd3; expect_lit("ren_x3", 0, 1'b1, 3'd4, 32'd0); step(1'b1);
      commit_en = 1'b1; commit_reg = 5'd3; commit_index = 3'd4; commit_data = 32'd7;
      rs1_reg = 5'd3; expect_lit("bypass_x3", 0, 1'b0, 3'd0, 32'd7); step(1'b1);
      rs1_reg = 5'd3; expect_lit("commit_x3", 0, 1'b0, 3'd0, 32'd7); step(1'b1);

      // stale tag
      rename_en = 1'b1; rename_reg = 5'd3; rename_index = 3'd1; step(1'b1);
      rename_en = 1'b1; rename_reg = 5'd3; rename_index = 3'd5; step(1'b1);
      commit_en = 1'b1; commit_reg = 5'd3; commit_index = 3'd1; commit_data = 32'd9;
      rs1_reg = 5'd3; expect_lit("stale_same", 0, 1'b1, 3'd5, 32'd9); step(1'b1);
      rs1_reg = 5'd3; expect_lit("stale_x3", 0, 1'b1, 3'd5, 32'd9); step(1'b1);

      // same-cycle commit and rename
      rename_en = 1'b1; rename_reg = 5'd7; rename_index = 3'd2; step(1'b1);
      commit_en = 1'b1; commit_reg = 5'd7; commit_index = 3'd2; commit_data = 32'd11;
      rename_en = 1'b1; rename_reg = 5'd7; rename_index = 3'd6;
      rs1_reg = 5'd7; expect_lit("coll_bypass", 0, 1'b0, 3'd0, 32'd11); step(1'b1);
      rs1_reg = 5'd7; expect_lit("coll_x7", 0, 1'b1, 3'd6, 32'd11); step(1'b1);

      // flush
      fl_regs = '{5'd1, 5'd2, 5'd31, 5'd4};
      fl_vals = '{32'h11, 32'h22, 32'h31, 32'h44};
      for (int i = 0; i < 4; i++) begin
         commit_en = 1'b1; commit_reg = fl_regs[i]; commit_data = fl_vals[i]; step(1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         rename_en = 1'b1; rename_reg = fl_regs[i]; rename_index = 3'(i + 1); step(1'b1);
      end
      flush_signal = 1'b1; rename_en = 1'b1; rename_reg = 5'd4; rename_index = 3'd5; step(1'b1);
      rs1_reg = 5'd1; rs2_reg = 5'd2;
      expect_lit("flush_x1", 0, 1'b0, 3'd0, 32'h11);
      expect_lit("flush_x2", 1, 1'b0, 3'd0, 32'h22);
      step(1'b1);
      rs1_reg = 5'd31; rs2_reg = 5'd4;
      expect_lit("flush_x31", 0, 1'b0, 3'd0, 32'h31);
      expect_lit("flush_x4", 1, 1'b0, 3'd0, 32'h44);
      step(1'b1);

      // x0 and rdy_in low
      commit_en = 1'b1; commit_reg = 5'd0; commit_data = 32'd5;
      rename_en = 1'b1; rename_reg = 5'd0; rename_index = 3'd3;
      rs1_reg = 5'd0; expect_lit("x0_same", 0, 1'b0, 3'd0, 32'd0); step(1'b1);
      rs1_reg = 5'd0; expect_lit("x0_after", 0, 1'b0, 3'd0, 32'd0); step(1'b1);
      rdy_in = 1'b0; commit_en = 1'b1; commit_reg = 5'd8; commit_data = 32'd3;
      rename_en = 1'b1; rename_reg = 5'd8; rename_index = 3'd2;
      rs1_reg = 5'd8; expect_lit("rdy_lo_same", 0, 1'b0, 3'd0, 32'd0); step(1'b1);
      rs1_reg = 5'd8; expect_lit("rdy_lo_x8", 0, 1'b0, 3'd0, 32'd0); step(1'b1);

      // randomized traffic concentrated on a few registers
      for (int i = 0; i < 400; i++) begin
         rdy_in       = ($urandom_range(0, 7) != 0);
         commit_en    = $urandom_range(0, 1) == 1;
         commit_reg   = pick();
         commit_index = ($urandom_range(0, 1) == 1) ? m_tag[commit_reg] : 3'($urandom);
         commit_data  = $urandom;
         rename_en    = $urandom_range(0, 1) == 1;
         rename_reg   = pick();
         rename_index = 3'($urandom);
         flush_signal = ($urandom_range(0, 15) == 0);
         rs1_reg      = ($urandom_range(0, 1) == 1) ? commit_reg : pick();
         rs2_reg      = pick();
         step(1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
